// File: rtl/elbeth_pkg.sv
// ============================================================================
// Module : elbeth_pkg
// Brief  : Shared constants and fetch FSM encodings for the elbeth core.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package elbeth_pkg;

   localparam logic [31:0] c_nop_instr = 32'h0000_0013;
   localparam logic [31:0] c_reset_pc  = 32'h0000_0200;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } fetch_state_t;

   function automatic logic [63:0] pack_fetch(input logic [31:0] pc,
                                              input logic [31:0] instr);
      return {pc, instr};
   endfunction

endpackage

`default_nettype wire

// File: rtl/elbeth_fetch_skid.sv
// ============================================================================
// Module : elbeth_fetch_skid
// Brief  : One-entry {pc, instr} holding buffer used while decode is stalled.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module elbeth_fetch_skid (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic        i_drain,
   input  logic        i_clear,
   input  logic [63:0] i_data,
   output logic [63:0] o_data,
   output logic        o_full
);

   logic [63:0] r_data;
   logic        r_full;

   // Clear wins over load so a redirect can never leave a stale entry behind.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_data <= 64'd0;
         r_full <= 1'b0;
      end else if (i_clear) begin
         r_full <= 1'b0;
      end else if (i_load) begin
         r_data <= i_data;
         r_full <= 1'b1;
      end else if (i_drain) begin
         r_full <= 1'b0;
      end
   end

   assign o_data = r_data;
   assign o_full = r_full;

endmodule

`default_nettype wire

// File: rtl/elbeth_fetch_unit.sv
// ============================================================================
// Module : elbeth_fetch_unit
// Brief  : Instruction fetch stage: imem handshake, IF/ID register, skid.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module elbeth_fetch_unit
   import elbeth_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = c_reset_pc,
   parameter logic [31:0] NOP_INSTR = c_nop_instr
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_pc,
   input  logic        i_ctrl_stall,
   input  logic        i_ctrl_flush,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ready,
   input  logic [31:0] i_imem_rdata,
   output logic        o_fetch_stall,
   output logic [31:0] o_seq_pc,
   output logic [31:0] o_id_pc,
   output logic [31:0] o_id_instr,
   output logic        o_id_valid
);

   fetch_state_t r_state;
   logic [31:0]  r_req_addr;
   logic [31:0]  r_id_pc;
   logic [31:0]  r_id_instr;
   logic         r_id_valid;

   logic         w_xfer;
   logic         w_live;
   logic         w_accept;
   logic         w_buf_full;
   logic         w_buf_load;
   logic         w_buf_drain;
   logic [63:0]  w_buf_data;

   always_comb begin
      o_imem_req  = 1'b0;
      o_imem_addr = i_pc;
      case (r_state)
         ST_IDLE: begin
            o_imem_req  = !w_buf_full;
            o_imem_addr = i_pc;
         end
         default: begin
            o_imem_req  = 1'b1;
            o_imem_addr = r_req_addr;
         end
      endcase
      if (!rst) begin
         o_imem_req = 1'b0;
      end
   end

   // A transfer in DROP completes the bus handshake but carries dead data.
   assign w_xfer        = o_imem_req && i_imem_ready;
   assign w_live        = w_xfer && (r_state != ST_DROP);
   assign w_accept      = w_live && !i_ctrl_flush;
   assign o_fetch_stall = !w_live && !i_ctrl_flush;
   assign o_seq_pc      = i_pc + 32'd4;

   assign w_buf_load  = w_accept && i_ctrl_stall;
   assign w_buf_drain = w_buf_full && !i_ctrl_stall && !i_ctrl_flush;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_req_addr <= RESET_PC;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (o_imem_req && !i_imem_ready) begin
                  r_req_addr <= i_pc;
                  r_state    <= i_ctrl_flush ? ST_DROP : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (w_xfer) begin
                  r_state <= ST_IDLE;
               end else if (i_ctrl_flush) begin
                  r_state <= ST_DROP;
               end
            end
            ST_DROP: begin
               if (w_xfer) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_id_valid <= 1'b0;
         r_id_instr <= NOP_INSTR;
         r_id_pc    <= RESET_PC;
      end else if (i_ctrl_flush) begin
         r_id_valid <= 1'b0;
         r_id_instr <= NOP_INSTR;
      end else if (i_ctrl_stall) begin
         r_id_valid <= r_id_valid;
      end else if (w_buf_full) begin
         r_id_valid <= 1'b1;
         r_id_pc    <= w_buf_data[63:32];
         r_id_instr <= w_buf_data[31:0];
      end else if (w_accept) begin
         r_id_valid <= 1'b1;
         r_id_pc    <= o_imem_addr;
         r_id_instr <= i_imem_rdata;
      end else begin
         r_id_valid <= 1'b0;
         r_id_instr <= NOP_INSTR;
      end
   end

   elbeth_fetch_skid u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_buf_load),
      .i_drain (w_buf_drain),
      .i_clear (i_ctrl_flush),
      .i_data  (pack_fetch(o_imem_addr, i_imem_rdata)),
      .o_data  (w_buf_data),
      .o_full  (w_buf_full)
   );

   assign o_id_pc    = r_id_pc;
   assign o_id_instr = r_id_instr;
   assign o_id_valid = r_id_valid;

endmodule

`default_nettype wire

// File: tb/tb_elbeth_fetch_unit.sv
// ============================================================================
// Module : tb_elbeth_fetch_unit
// Brief  : Directed self-checking bench for elbeth_fetch_unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_elbeth_fetch_unit;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic        stall;
   logic        flush;
   logic        req;
   logic [31:0] addr;
   logic        ready;
   logic [31:0] rdata;
   logic        fstall;
   logic [31:0] seq_pc;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_valid;

   int checks   = 0;
   int failures = 0;

   elbeth_fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .i_pc          (pc),
      .i_ctrl_stall  (stall),
      .i_ctrl_flush  (flush),
      .o_imem_req    (req),
      .o_imem_addr   (addr),
      .i_imem_ready  (ready),
      .i_imem_rdata  (rdata),
      .o_fetch_stall (fstall),
      .o_seq_pc      (seq_pc),
      .o_id_pc       (id_pc),
      .o_id_instr    (id_instr),
      .o_id_valid    (id_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1300_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; pc = 32'hFFFF_FFFC; stall = 1'b0; flush = 1'b0;
      ready = 1'b1; rdata = 32'd0;
      #1;
      chk("seq_pc_wrap", seq_pc, 32'h0);
      chk("req_in_reset", {31'd0, req}, 32'd0);
      pc = 32'h200; rdata = mem_word(32'h200);
      tick(); tick();
      chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
      chk("rst_id_instr", id_instr, 32'h0000_0013);
      chk("rst_id_pc", id_pc, 32'h200);

      // Zero-wait streaming
      rst = 1'b1; #1;
      chk("t1_req", {31'd0, req}, 32'd1);
      chk("t1_addr", addr, 32'h200);
      chk("t1_fstall", {31'd0, fstall}, 32'd0);
      chk("t1_seq_pc", seq_pc, 32'h204);
      tick();
      chk("t1_id_pc0", id_pc, 32'h200);
      chk("t1_id_valid0", {31'd0, id_valid}, 32'd1);
      chk("t1_id_instr0", id_instr, mem_word(32'h200));
      for (int k = 1; k < 4; k++) begin
         pc = 32'h200 + 32'(4 * k); rdata = mem_word(pc); #1;
         chk("t1_fstall_n", {31'd0, fstall}, 32'd0);
         tick();
         chk("t1_id_pc_n", id_pc, 32'h200 + 32'(4 * k));
         chk("t1_id_valid_n", {31'd0, id_valid}, 32'd1);
      end

      // Three wait cycles at 0x210
      pc = 32'h210; ready = 1'b0; rdata = 32'd0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t2_addr", addr, 32'h210);
         chk("t2_req", {31'd0, req}, 32'd1);
         chk("t2_fstall", {31'd0, fstall}, 32'd1);
         tick();
         chk("t2_bubble_valid", {31'd0, id_valid}, 32'd0);
         chk("t2_bubble_instr", id_instr, 32'h0000_0013);
      end
      ready = 1'b1; rdata = mem_word(32'h210); #1;
      chk("t2_fstall_done", {31'd0, fstall}, 32'd0);
      tick();
      chk("t2_id_pc", id_pc, 32'h210);
      chk("t2_id_valid", {31'd0, id_valid}, 32'd1);

      // Flush while waiting on 0x220
      pc = 32'h220; ready = 1'b0; #1;
      chk("t3_fstall_wait", {31'd0, fstall}, 32'd1);
      tick();
      flush = 1'b1; #1;
      chk("t3_fstall_flush", {31'd0, fstall}, 32'd0);
      chk("t3_addr_flush", addr, 32'h220);
      tick();
      chk("t3_flush_valid", {31'd0, id_valid}, 32'd0);
      flush = 1'b0; pc = 32'h400; #1;
      chk("t3_drop_addr", addr, 32'h220);
      chk("t3_drop_req", {31'd0, req}, 32'd1);
      chk("t3_drop_fstall", {31'd0, fstall}, 32'd1);
      tick();
      ready = 1'b1; rdata = mem_word(32'h220); #1;
      chk("t3_drop_xfer_fstall", {31'd0, fstall}, 32'd1);
      tick();
      chk("t3_discard_valid", {31'd0, id_valid}, 32'd0);
      rdata = mem_word(32'h400); #1;
      chk("t3_redirect_addr", addr, 32'h400);
      chk("t3_redirect_fstall", {31'd0, fstall}, 32'd0);
      tick();
      chk("t3_id_pc", id_pc, 32'h400);
      chk("t3_id_valid", {31'd0, id_valid}, 32'd1);
      chk("t3_id_instr", id_instr, mem_word(32'h400));

      // Decode stall with skid fill and drain
      pc = 32'h230; rdata = mem_word(32'h230);
      tick();
      chk("t4_id_pc_230", id_pc, 32'h230);
      pc = 32'h234; rdata = mem_word(32'h234); stall = 1'b1; #1;
      chk("t4_req_fill", {31'd0, req}, 32'd1);
      chk("t4_fstall_fill", {31'd0, fstall}, 32'd0);
      tick();
      chk("t4_hold_pc", id_pc, 32'h230);
      chk("t4_hold_valid", {31'd0, id_valid}, 32'd1);
      pc = 32'h238; rdata = mem_word(32'h238);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t4_req_full", {31'd0, req}, 32'd0);
         chk("t4_fstall_full", {31'd0, fstall}, 32'd1);
         tick();
         chk("t4_hold_pc_n", id_pc, 32'h230);
      end
      stall = 1'b0; #1;
      chk("t4_req_drain", {31'd0, req}, 32'd0);
      tick();
      chk("t4_drain_pc", id_pc, 32'h234);
      chk("t4_drain_instr", id_instr, mem_word(32'h234));
      chk("t4_drain_valid", {31'd0, id_valid}, 32'd1);
      #1;
      chk("t4_req_after", {31'd0, req}, 32'd1);
      chk("t4_addr_after", addr, 32'h238);
      tick();
      chk("t4_id_pc_238", id_pc, 32'h238);

      // Flush with stall and a full buffer
      pc = 32'h23C; rdata = mem_word(32'h23C); stall = 1'b1;
      tick();
      chk("t5_hold_pc", id_pc, 32'h238);
      pc = 32'h240; flush = 1'b1; #1;
      chk("t5_req_full", {31'd0, req}, 32'd0);
      chk("t5_fstall_flush", {31'd0, fstall}, 32'd0);
      tick();
      chk("t5_flush_valid", {31'd0, id_valid}, 32'd0);
      chk("t5_flush_instr", id_instr, 32'h0000_0013);
      flush = 1'b0; stall = 1'b0; pc = 32'h500; rdata = mem_word(32'h500); #1;
      chk("t5_req_cleared", {31'd0, req}, 32'd1);
      chk("t5_addr_redirect", addr, 32'h500);
      tick();
      chk("t5_id_pc", id_pc, 32'h500);
      chk("t5_id_instr", id_instr, mem_word(32'h500));
      chk("t5_id_valid", {31'd0, id_valid}, 32'd1);

      // Reset while a request is pending
      pc = 32'h504; ready = 1'b0;
      tick();
      #1;
      chk("t6_wait_req", {31'd0, req}, 32'd1);
      chk("t6_wait_addr", addr, 32'h504);
      rst = 1'b0; #1;
      chk("t6_req_forced", {31'd0, req}, 32'd0);
      tick();
      pc = 32'h200; #1;
      chk("t6_req_in_reset", {31'd0, req}, 32'd0);
      tick();
      chk("t6_rst_valid", {31'd0, id_valid}, 32'd0);
      chk("t6_rst_instr", id_instr, 32'h0000_0013);
      chk("t6_rst_pc", id_pc, 32'h200);
      rst = 1'b1; ready = 1'b1; rdata = mem_word(32'h200); #1;
      chk("t6_fresh_req", {31'd0, req}, 32'd1);
      chk("t6_fresh_addr", addr, 32'h200);
      tick();
      chk("t6_fresh_pc", id_pc, 32'h200);
      chk("t6_fresh_valid", {31'd0, id_valid}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
